// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-read pixel FIFO into a
// valid/ready raster stream with start-of-frame / end-of-line flags.
//
// Ports:
//   i_clk, i_rstn        clock, async active-low reset
//   i_fifo_empty         FIFO empty flag (used combinationally)
//   i_fifo_data          FIFO read data, valid one cycle after o_fifo_rd
//   o_fifo_rd            FIFO read strobe (combinational)
//   o_tdata/o_tvalid     stream pixel / valid
//   i_tready             downstream ready
//   o_tuser              start of frame, pixel (0,0)
//   o_tlast              end of line, pixel x = H_ACTIVE-1
//   o_x, o_y             raster position of o_tdata
//   o_frame_done         pulse the cycle after a frame's last pixel pops
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tuser,
  output logic                  o_tlast,
  output logic [XW-1:0]         o_x,
  output logic [YW-1:0]         o_y,
  output logic                  o_frame_done
);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head_q;
  logic [1:0]            count_q;
  logic                  rd_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic                  frame_done_q;

  logic       pop;
  logic       tail;
  logic       x_end;
  logic       y_end;
  logic [2:0] occ;
  logic [2:0] count_nxt;

  assign pop   = o_tvalid && i_tready;
  assign x_end = (x_q == XW'(H_ACTIVE - 1));
  assign y_end = (y_q == YW'(V_ACTIVE - 1));

  // Slots already claimed: buffered pixels plus the read whose data
  // lands this cycle. A new read needs a slot free one cycle later.
  assign occ = {1'b0, count_q} + {2'b0, rd_q};

  assign o_fifo_rd = !i_fifo_empty &&
                     ((occ < 3'd2) || ((occ == 3'd2) && pop));

  // Write slot is head+count; with a full buffer popping, that is
  // the slot being vacated by the head this cycle.
  assign tail = head_q ^ count_q[0];

  assign count_nxt = {1'b0, count_q} + {2'b0, rd_q} - {2'b0, pop};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
      rd_q     <= 1'b0;
    end else begin
      rd_q    <= o_fifo_rd;
      count_q <= count_nxt[1:0];
      if (rd_q)
        buf_q[tail] <= i_fifo_data;
      if (pop)
        head_q <= ~head_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= pop && x_end && y_end;
      if (pop) begin
        if (x_end) begin
          x_q <= '0;
          if (y_end)
            y_q <= '0;
          else
            y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  always @(posedge i_clk) begin
    if (i_rstn)
      buf_overflow: assert (count_nxt <= 3'd2);
  end

  assign o_tvalid     = (count_q != 2'd0);
  assign o_tdata      = buf_q[head_q];
  assign o_tuser      = o_tvalid && (x_q == '0) && (y_q == '0);
  assign o_tlast      = o_tvalid && x_end;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench for fifo_stream_reader with a
// registered-read FIFO model and a pixel/raster scoreboard.
module tb_fifo_stream_reader;

  localparam int DW = 12;
  localparam int H  = 4;
  localparam int V  = 2;

  logic          clk;
  logic          rstn;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;
  logic [1:0]    ox;
  logic [0:0]    oy;
  logic          frame_done;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .XW(2),
    .YW(1)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data),
    .o_fifo_rd(fifo_rd),
    .o_tdata(tdata),
    .o_tvalid(tvalid),
    .i_tready(tready),
    .o_tuser(tuser),
    .o_tlast(tlast),
    .o_x(ox),
    .o_y(oy),
    .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int reads, pops, mx, my;
  int tlast_n, tuser_n, fd_n, y1_n;
  logic fd_exp, prev_stall, last_tuser;
  logic [DW-1:0] prev_data, last_data;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    q.push_back(v);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic tick();
    logic rd;
    logic pop;
    #1;
    rd  = fifo_rd;
    pop = tvalid && tready;
    chk("no_rd_empty", fifo_rd && fifo_empty, 0);
    chk("outstanding", (reads - pops) <= 2, 1);
    chk("frame_done", frame_done, fd_exp);
    chk("x", ox, mx);
    chk("y", oy, my);
    chk("tuser", tuser, tvalid && mx == 0 && my == 0);
    chk("tlast", tlast, tvalid && mx == H - 1);
    if (prev_stall) begin
      chk("hold_valid", tvalid, 1);
      chk("hold_data", tdata, prev_data);
    end
    if (frame_done) fd_n++;
    fd_exp = 1'b0;
    if (pop) begin
      chk("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        chk("data", tdata, exp_q.pop_front());
      last_data  = tdata;
      last_tuser = tuser;
      if (tlast) tlast_n++;
      if (tuser) tuser_n++;
      if (oy == 1'b1) y1_n++;
      pops++;
      if (mx == H - 1) begin
        mx = 0;
        if (my == V - 1) begin
          my = 0;
          fd_exp = 1'b1;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    if (rd) reads++;
    @(posedge clk);
    #1;
    if (rd && q.size() != 0)
      fifo_data = q.pop_front();
    else
      fifo_data = 12'hBAD;
    fifo_empty = (q.size() == 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    fifo_data  = '0;
    mx = 0;
    my = 0;
    reads = 0;
    pops  = 0;
    fd_exp     = 1'b0;
    prev_stall = 1'b0;
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_x", ox, 0);
    chk("rst_y", oy, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_rd", fifo_rd, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, p0, t0, u0, f0, y0;
    tready  = 1'b0;
    tlast_n = 0;
    tuser_n = 0;
    fd_n    = 0;
    y1_n    = 0;
    do_reset();
    tick();
    tick();

    // first pixels: read, capture, then valid
    tready = 1'b1;
    push(12'h001);
    push(12'h002);
    push(12'h003);
    #1;
    chk("rd_first", fifo_rd, 1);
    chk("valid_c0", tvalid, 0);
    tick();
    chk("valid_c1", tvalid, 0);
    tick();
    chk("valid_c2", tvalid, 1);
    chk("data_c2", tdata, 12'h001);
    chk("tuser_c2", tuser, 1);
    tick();
    chk("data_c3", tdata, 12'h002);
    chk("tuser_c3", tuser, 0);
    tick();
    chk("data_c4", tdata, 12'h003);
    tick();
    chk("valid_c5", tvalid, 0);
    chk("drain1", exp_q.size(), 0);

    // stalled with a pre-filled FIFO
    tready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    r0 = reads;
    repeat (10) tick();
    chk("stall_reads", reads - r0, 2);
    chk("stall_valid", tvalid, 1);
    chk("stall_data", tdata, 12'h001);
    tready = 1'b1;
    p0 = pops;
    repeat (8) tick();
    chk("no_bubble", pops - p0, 8);
    chk("drain2", exp_q.size(), 0);

    // random backpressure
    for (int i = 0; i < 1000; i++) push(DW'($urandom_range(0, 4095)));
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 6000) begin
        tready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    chk("drain_rand", exp_q.size(), 0);
    tready = 1'b1;
    repeat (3) tick();

    // one full frame plus the first pixel of the next
    do_reset();
    tready = 1'b1;
    t0 = tlast_n;
    u0 = tuser_n;
    f0 = fd_n;
    y0 = y1_n;
    for (int i = 1; i <= 9; i++) push(DW'(12'h100 + i));
    drain(100);
    repeat (2) tick();
    chk("frame_tlast", tlast_n - t0, 2);
    chk("frame_tuser", tuser_n - u0, 2);
    chk("frame_done_n", fd_n - f0, 1);
    chk("frame_y1", y1_n - y0, 4);
    chk("frame_last", last_data, 12'h109);
    chk("frame_last_tuser", last_tuser, 1);

    // reset with a read in flight and a pixel buffered
    tready = 1'b0;
    for (int i = 1; i <= 4; i++) push(DW'(12'h200 + i));
    tick();
    tick();
    chk("pre_rst_valid", tvalid, 1);
    chk("pre_rst_rd_q", dut.rd_q, 1);
    do_reset();
    tready = 1'b1;
    push(12'h0AA);
    drain(20);
    chk("post_rst_data", last_data, 12'h0AA);
    chk("post_rst_tuser", last_tuser, 1);

    // FIFO empty every other cycle
    r0 = reads;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      push(DW'(12'h300 + i));
      tick();
      tick();
    end
    drain(20);
    repeat (3) tick();
    chk("toggle_reads", reads - r0, 10);
    chk("toggle_pops", pops - p0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
